// File: rtl/transition_vector_assembler_if.sv
// Handshake bundle between the serial word source, the assembler and the vector consumer.
// master is the assembler's view; slave is the view of the surrounding environment.
interface transition_vector_assembler_if #(
    parameter int W = 32
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [W-1:0] out0;
    logic [W-1:0] out1;
    logic [W-1:0] out2;
    logic [W-1:0] out3;
    logic [W-1:0] out4;
    logic [W-1:0] out5;
    logic         m_valid;
    logic         m_ready;
    logic         frame_err;
    logic [7:0]   err_count;

    modport master (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, out0, out1, out2, out3, out4, out5, m_valid, frame_err, err_count
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, out0, out1, out2, out3, out4, out5, m_valid, frame_err, err_count
    );
endinterface

// File: rtl/transition_vector_assembler.sv
// Groups a serial stream of six Q17.14 words into one parallel transition vector, using a
// collect slot (A) and a present slot (B); malformed frames are dropped and counted.
module transition_vector_assembler #(
    parameter int W      = 32,
    parameter int NWORDS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    transition_vector_assembler_if.master bus
);
    localparam int                 IDX_W    = $clog2(NWORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q [NWORDS];
    logic [W-1:0]     a_d [NWORDS];
    logic [W-1:0]     b_q [NWORDS];
    logic [W-1:0]     b_d [NWORDS];
    logic             a_full_q, a_full_d;
    logic             b_valid_q, b_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             rst_q;

    logic             out_xfer;
    logic             in_xfer;
    logic             b_free;
    logic             s_ready_int;
    logic             err_evt;

    // B counts as free when it is empty or being popped this very cycle, so A can advance with no bubble.
    assign out_xfer    = b_valid_q && bus.m_ready;
    assign b_free      = !b_valid_q || out_xfer;
    assign s_ready_int = !rst_q && !(a_full_q && !b_free);
    assign in_xfer     = bus.s_valid && s_ready_int;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_full_d    = a_full_q;
        b_valid_d   = b_valid_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_evt     = 1'b0;
        for (int k = 0; k < NWORDS; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
        end

        if (out_xfer) begin
            b_valid_d = 1'b0;
        end

        // A completed earlier but had to wait for B.
        if (a_full_q && b_free) begin
            for (int k = 0; k < NWORDS; k++) begin
                b_d[k] = a_q[k];
            end
            b_valid_d = 1'b1;
            a_full_d  = 1'b0;
        end

        if (in_xfer) begin
            case (state_q)
                ST_DRAIN: begin
                    if (bus.s_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    a_d[idx_q] = bus.s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (bus.s_last) begin
                            state_d = ST_IDLE;
                            // Bypass straight into B so m_valid rises the cycle after the last word.
                            if (b_free) begin
                                for (int k = 0; k < NWORDS; k++) begin
                                    b_d[k] = a_d[k];
                                end
                                b_valid_d = 1'b1;
                            end else begin
                                a_full_d = 1'b1;
                            end
                        end else begin
                            err_evt = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else if (bus.s_last) begin
                        err_evt = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_COLLECT;
                    end
                end
            endcase
        end

        if (err_evt) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q       <= 1'b1;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_full_q    <= 1'b0;
            b_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rst_q       <= 1'b0;
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_full_q    <= a_full_d;
            b_valid_q   <= b_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                a_q[gi] <= '0;
                b_q[gi] <= '0;
            end else begin
                a_q[gi] <= a_d[gi];
                b_q[gi] <= b_d[gi];
            end
        end
    end

    assign bus.s_ready   = s_ready_int;
    assign bus.m_valid   = b_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_cnt_q;
    assign bus.out0      = b_q[0];
    assign bus.out1      = b_q[1];
    assign bus.out2      = b_q[2];
    assign bus.out3      = b_q[3];
    assign bus.out4      = b_q[4];
    assign bus.out5      = b_q[5];
endmodule

// File: tb/tb_transition_vector_assembler.sv
// Directed bench for transition_vector_assembler: a frame table plus hand-written
// back-pressure, reset and error-saturation sequences.
module tb_transition_vector_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    transition_vector_assembler_if #(.W(32)) bus ();

    transition_vector_assembler #(.W(32), .NWORDS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int errors   = 0;

    // Monitor: sampled on the falling edge, away from the active edge.
    int          acc_cnt    = 0;
    int          err_pulses = 0;
    int          got_wr     = 0;
    logic [31:0] got_mem [64][6];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_valid && bus.s_ready) acc_cnt <= acc_cnt + 1;
            if (bus.frame_err) err_pulses <= err_pulses + 1;
            if (bus.m_valid && bus.m_ready) begin
                got_mem[got_wr % 64][0] <= bus.out0;
                got_mem[got_wr % 64][1] <= bus.out1;
                got_mem[got_wr % 64][2] <= bus.out2;
                got_mem[got_wr % 64][3] <= bus.out3;
                got_mem[got_wr % 64][4] <= bus.out4;
                got_mem[got_wr % 64][5] <= bus.out5;
                got_wr <= got_wr + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int waitc = 0;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.s_ready) begin
            n_checks++;
            errors++;
            $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", waitc);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < n; k++) begin
            logic [31:0] kk;
            kk = 32'(k);
            send_word(base + kk * step, k == n - 1);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_s_ready"},   {31'b0, bus.s_ready},   32'd0);
        chk({tag, "_rst_m_valid"},   {31'b0, bus.m_valid},   32'd0);
        chk({tag, "_rst_frame_err"}, {31'b0, bus.frame_err}, 32'd0);
        chk({tag, "_rst_err_count"}, {24'b0, bus.err_count}, 32'd0);
        chk({tag, "_rst_out0"},      bus.out0,               32'd0);
        chk({tag, "_rst_out5"},      bus.out5,               32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_post_rst_s_ready"}, {31'b0, bus.s_ready}, 32'd1);
    endtask

    task automatic chk_vec(input string tag, input int slot, input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] kk;
            kk = 32'(k);
            chk($sformatf("%s_w%0d", tag, k), got_mem[slot % 64][k], base + kk * step);
        end
    endtask

    typedef struct {
        int          nwords;
        logic [31:0] base;
        logic [31:0] step;
        bit          ok;
    } frame_rec_t;

    frame_rec_t tbl [7];

    initial begin
        int rd;
        int exp_err;
        int wr0;
        int pulses0;
        int acc0;

        tbl[0] = '{6, 32'h0000_4000, 32'h0000_4000, 1'b1};
        tbl[1] = '{4, 32'h0000_0001, 32'h0000_0001, 1'b0};
        tbl[2] = '{6, 32'hFFFF_C000, 32'h0000_0000, 1'b1};
        tbl[3] = '{8, 32'h0000_0100, 32'h0000_0010, 1'b0};
        tbl[4] = '{6, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        tbl[5] = '{1, 32'h0000_AAAA, 32'h0000_0000, 1'b0};
        tbl[6] = '{6, 32'h8000_0000, 32'h0000_0001, 1'b1};

        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        exp_err     = 0;

        do_reset("init");

        // Single frame latency: m_valid high right after the edge that takes word 6.
        bus.m_ready = 1'b1;
        send_frame(6, 32'h0000_4000, 32'h0000_4000);
        chk("lat_m_valid", {31'b0, bus.m_valid}, 32'd1);
        chk("lat_out0",    bus.out0,             32'h0000_4000);
        chk("lat_out5",    bus.out5,             32'h0001_8000);
        repeat (3) @(posedge clk);
        #1;
        chk("lat_m_valid_drop", {31'b0, bus.m_valid}, 32'd0);
        rd = got_wr;

        for (int r = 0; r < 7; r++) begin
            wr0     = got_wr;
            pulses0 = err_pulses;
            send_frame(tbl[r].nwords, tbl[r].base, tbl[r].step);
            repeat (3) @(posedge clk);
            #1;
            if (tbl[r].ok) begin
                chk($sformatf("row%0d_nvec", r), 32'(got_wr - wr0), 32'd1);
                chk_vec($sformatf("row%0d", r), rd, tbl[r].base, tbl[r].step);
            end else begin
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                chk($sformatf("row%0d_nvec", r), 32'(got_wr - wr0), 32'd0);
            end
            chk($sformatf("row%0d_err_count", r), {24'b0, bus.err_count}, 32'(exp_err));
            chk($sformatf("row%0d_err_pulses", r), 32'(err_pulses - pulses0), tbl[r].ok ? 32'd0 : 32'd1);
            rd = got_wr;
        end

        // Back-pressure: two frames fill B and A, the third stalls until the consumer drains.
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        wr0  = got_wr;
        acc0 = acc_cnt;
        send_frame(6, 32'h0001_0000, 32'h0000_0001);
        send_frame(6, 32'h0002_0000, 32'h0000_0001);
        chk("bp_s_ready_low", {31'b0, bus.s_ready}, 32'd0);
        fork
            send_frame(6, 32'h0003_0000, 32'h0000_0001);
        join_none
        repeat (4) @(posedge clk);
        #1;
        chk("bp_acc_stalled", 32'(acc_cnt - acc0), 32'd12);
        chk("bp_m_valid",     {31'b0, bus.m_valid}, 32'd1);
        chk("bp_out0_held",   bus.out0, 32'h0001_0000);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 200 && (got_wr - wr0) < 3; c++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("bp_nvec", 32'(got_wr - wr0), 32'd3);
        chk_vec("bp_v0", wr0,     32'h0001_0000, 32'h0000_0001);
        chk_vec("bp_v1", wr0 + 1, 32'h0002_0000, 32'h0000_0001);
        chk_vec("bp_v2", wr0 + 2, 32'h0003_0000, 32'h0000_0001);
        chk("bp_acc_total", 32'(acc_cnt - acc0), 32'd18);
        rd = got_wr;

        // Reset mid-frame, then a clean frame.
        send_word(32'h0000_1111, 1'b0);
        send_word(32'h0000_2222, 1'b0);
        send_word(32'h0000_3333, 1'b0);
        do_reset("midframe");
        wr0 = got_wr;
        send_frame(6, 32'h0005_0000, 32'h0000_0100);
        repeat (3) @(posedge clk);
        #1;
        chk("midframe_nvec", 32'(got_wr - wr0), 32'd1);
        chk_vec("midframe_vec", wr0, 32'h0005_0000, 32'h0000_0100);

        // Reset while a vector is presented.
        bus.m_ready = 1'b0;
        send_frame(6, 32'h0006_0000, 32'h0000_0001);
        chk("present_m_valid", {31'b0, bus.m_valid}, 32'd1);
        do_reset("present");
        chk("present_out1", bus.out1, 32'd0);
        chk("present_out2", bus.out2, 32'd0);
        chk("present_out3", bus.out3, 32'd0);
        chk("present_out4", bus.out4, 32'd0);
        bus.m_ready = 1'b1;
        wr0 = got_wr;
        send_frame(6, 32'hFFFF_0000, 32'h0000_4000);
        repeat (3) @(posedge clk);
        #1;
        chk("present_nvec", 32'(got_wr - wr0), 32'd1);
        chk_vec("present_vec", wr0, 32'hFFFF_0000, 32'h0000_4000);

        // 260 one-word frames: counter saturates while pulses keep coming.
        pulses0 = err_pulses;
        for (int f = 0; f < 260; f++) begin
            send_word(32'(f), 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sat_err_count",  {24'b0, bus.err_count}, 32'd255);
        chk("sat_err_pulses", 32'(err_pulses - pulses0), 32'd260);
        chk("sat_frame_err_idle", {31'b0, bus.frame_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
        $fatal(1, "timeout");
    end
endmodule
